// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and restoring divide on one datapath.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle XLEN x XLEN multiplier instead of iterating.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_opt,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy
);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        opt_q;
    logic [XLEN-1:0]   hi_q, lo_q, mcd_q, res_q;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic              neg_q, valid_q;

    // Operand conditioning at accept
    logic            sgn1, sgn2, s1n, s2n, neg_in, div_zero, ovf;
    logic [XLEN-1:0] mag1, mag2, spec_res;

    assign sgn1     = (i_opt == OP_MULH) | (i_opt == OP_MULHSU) | (i_opt == OP_DIV) | (i_opt == OP_REM);
    assign sgn2     = (i_opt == OP_MULH) | (i_opt == OP_DIV) | (i_opt == OP_REM);
    assign s1n      = sgn1 & i_src1[XLEN-1];
    assign s2n      = sgn2 & i_src2[XLEN-1];
    assign mag1     = s1n ? -i_src1 : i_src1;
    assign mag2     = s2n ? -i_src2 : i_src2;
    assign neg_in   = (i_opt == OP_REM) ? s1n : (s1n ^ s2n);
    assign div_zero = i_opt[2] & (i_src2 == '0);
    assign ovf      = sgn2 & i_opt[2] & (i_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_src2);
    assign spec_res = div_zero ? (i_opt[1] ? i_src1 : '1) : (i_opt[1] ? '0 : i_src1);

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fp;
    logic [XLEN-1:0]          fast_res;

    assign fa       = $signed({s1n, i_src1});
    assign fb       = $signed({s2n, i_src2});
    assign fp       = fa * fb;
    assign fast_res = (i_opt == OP_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif

    // One iteration step; hi holds partial product / partial remainder
    logic [XLEN:0]   add_sum, shl, sub;
    logic [XLEN-1:0] fin;

    assign add_sum = {1'b0, hi_q} + {1'b0, mcd_q};
    assign shl     = {hi_q, lo_q[XLEN-1]};
    assign sub     = shl - {1'b0, mcd_q};

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (opt_q[2]) begin
            if (!sub[XLEN]) begin
                hi_d = sub[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shl[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
        end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
        end
    end

    // High half of a negated 2*XLEN product only carries in when the low half is zero
    always_comb begin
        fin = hi_d;
        case (opt_q)
            OP_MUL:                      fin = lo_d;
            OP_MULH, OP_MULHSU, OP_MULHU: fin = neg_q ? (~hi_d + XLEN'(lo_d == '0)) : hi_d;
            OP_DIV, OP_DIVU:             fin = neg_q ? -lo_d : lo_d;
            default:                     fin = neg_q ? -hi_d : hi_d;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcd_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else if (i_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    opt_q <= i_opt;
                    neg_q <= neg_in;
                    cnt_q <= '0;
                    hi_q  <= '0;
                    if (div_zero | ovf) begin
                        res_q   <= spec_res;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!i_opt[2]) begin
                        res_q   <= fast_res;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
`endif
                    else begin
                        lo_q    <= i_opt[2] ? mag1 : mag2;
                        mcd_q   <= i_opt[2] ? mag2 : mag1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        res_q   <= fin;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: if (i_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_valid = valid_q;
    assign o_res   = res_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=32): results, latency, backpressure, flush and reset.
module tb_mdu_iter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_opt = 3'd0;
    logic [31:0] i_src1 = '0;
    logic [31:0] i_src2 = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_res;
    logic        o_busy;

    int total = 0;
    int bad   = 0;
    int lat;
    logic seen;
    logic [31:0] held;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opt(i_opt), .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op; lat counts edges from the accept edge (=1) until o_valid is seen.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        @(negedge i_clk);
        i_valid = 1'b1; i_opt = op; i_src1 = a; i_src2 = b;
        @(posedge i_clk);
        n = 1;
        #1;
        i_valid = 1'b0; i_src1 = 32'hDEAD_BEEF; i_src2 = 32'h5555_AAAA;
        while (!o_valid && n < 100) begin
            @(posedge i_clk);
            n++;
            #1;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        run(op, a, b, n);
        chk({tag, "_res"}, o_res, exp);
        chk({tag, "_lat"}, n, exp_lat);
        @(posedge i_clk);
        #1;
        chk({tag, "_handoff"}, {o_ready, o_valid, o_busy}, 3'b100);
    endtask

    initial begin
        #1;
        chk("rst_state", {o_ready, o_valid, o_busy}, 3'b100);
        chk("rst_res", o_res, 32'h0);
        #16 i_rst = 1'b0;

        do_op("mul_7x-3",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mulh",       3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        do_op("mulhsu",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT);
        do_op("mulhu",      3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT);
        do_op("mulh_neg",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT);
        do_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        do_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        do_op("divu",       3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33);
        do_op("rem_7_-2",   3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        do_op("remu",       3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33);
        do_op("div_by0",    3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        do_op("divu_by0",   3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        do_op("remu_by0",   3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
        do_op("rem_by0",    3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1);
        do_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Backpressure in DONE
        i_ready = 1'b0;
        run(3'd5, 32'd100, 32'd7, lat);
        chk("bp_lat", lat, 33);
        held = o_res;
        chk("bp_res", held, 32'd14);
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk);
            #1;
            chk("bp_hold_ctl", {o_ready, o_valid, o_busy}, 3'b011);
            chk("bp_hold_res", o_res, 32'd14);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("bp_release", {o_ready, o_valid, o_busy}, 3'b100);
        chk("bp_res_kept", o_res, 32'd14);

        // Flush at CALC cycle 10 with a competing request
        @(negedge i_clk);
        i_valid = 1'b1; i_opt = 3'd4; i_src1 = 32'd1000; i_src2 = 32'd3;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1; i_valid = 1'b1; i_opt = 3'd5; i_src1 = 32'd9; i_src2 = 32'd0;
        @(posedge i_clk);
        #1;
        chk("flush_idle", {o_ready, o_valid, o_busy}, 3'b100);
        i_flush = 1'b0; i_valid = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            seen = seen | o_valid | o_busy;
        end
        chk("flush_no_valid", seen, 1'b0);
        chk("flush_res_kept", o_res, 32'd14);

        // Async reset mid-op
        @(negedge i_clk);
        i_valid = 1'b1; i_opt = 3'd1; i_src1 = 32'd3; i_src2 = 32'd5;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {o_ready, o_valid, o_busy}, 3'b100);
        chk("rst_mid_res", o_res, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            seen = seen | o_valid;
        end
        chk("rst_no_valid", seen, 1'b0);
        do_op("divu_after", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Flush in DONE together with i_ready
        i_ready = 1'b0;
        run(3'd7, 32'd23, 32'd5, lat);
        chk("fd_res", o_res, 32'd3);
        @(negedge i_clk);
        i_flush = 1'b1; i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("fd_idle", {o_ready, o_valid, o_busy}, 3'b100);
        i_flush = 1'b0;
        do_op("mul_big", 3'd0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, MUL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
